// File: rtl/regwr_arbiter.sv
// regwr_arbiter: merges the pipeline write-back (primary, absolute priority)
// and a multi-cycle unit (secondary, buffered in a DEPTH-entry FIFO) onto a
// single registered register-file write port. A primary write kills older
// buffered writes to the same register, so the newest data always wins.
// Decode-stage source registers are checked against live buffered entries.
// Optional feature macro: REGWR_ARB_FWD_EN forwards the youngest matching
// buffered data instead of requesting a stall.
module regwr_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        mc_valid_i,
    output logic        mc_ready_o,
    input  logic [4:0]  mc_addr_i,
    input  logic [31:0] mc_data_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        stall_o,
    output logic        fwd_rs_o,
    output logic [31:0] fwd_rs_data_o,
    output logic        fwd_rt_o,
    output logic [31:0] fwd_rt_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Buffer storage; valid_q marks entries still owed a write cycle.
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        we_q, we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic prim_grant, accept, push, head_present, head_live, pop, sec_grant;
    logic rs_hit, rt_hit;
`ifdef REGWR_ARB_FWD_EN
    logic [31:0] rs_data, rt_data;
`endif

    // Ready depends on reset too, so nothing is accepted on a reset edge.
    assign mc_ready_o = (count_q < CNT_W'(DEPTH)) && !rst_i;

    // Grant decision, FIFO bookkeeping and next write-port value.
    always_comb begin
        prim_grant   = wb_we_i && (wb_addr_i != 5'd0);
        accept       = mc_valid_i && mc_ready_o;
        // Register 0 writes are accepted but never stored.
        push         = accept && (mc_addr_i != 5'd0);
        head_present = (count_q != '0);
        head_live    = valid_q[rd_ptr_q];
        // A killed head drains on any edge; a live head only on a free edge.
        pop          = head_present && (!head_live || !prim_grant);
        sec_grant    = head_present && head_live && !prim_grant;

        valid_d = valid_q;
        if (prim_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == wb_addr_i) valid_d[i] = 1'b0;
            end
        end
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        // Applied after the kill so a same-edge younger secondary stays live.
        if (push) valid_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        we_d      = 1'b0;
        rd_addr_d = 5'd0;
        rd_data_d = 32'd0;
        if (prim_grant) begin
            we_d      = 1'b1;
            rd_addr_d = wb_addr_i;
            rd_data_d = wb_data_i;
        end else if (sec_grant) begin
            we_d      = 1'b1;
            rd_addr_d = addr_q[rd_ptr_q];
            rd_data_d = data_q[rd_ptr_q];
        end
    end

    // Control state and the registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Payload storage written on push.
    // NOTE: payload is not reset; valid_q gates every use, so stale contents are harmless.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= mc_addr_i;
            data_q[wr_ptr_q] <= mc_data_i;
        end
    end

    // Hazard scan oldest to youngest so the last match is the youngest.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
`ifdef REGWR_ARB_FWD_EN
        rs_data = 32'd0;
        rt_data = 32'd0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[idx] && (rs_addr_i != 5'd0) && (addr_q[idx] == rs_addr_i)) begin
                rs_hit = 1'b1;
`ifdef REGWR_ARB_FWD_EN
                rs_data = data_q[idx];
`endif
            end
            if (valid_q[idx] && (rt_addr_i != 5'd0) && (addr_q[idx] == rt_addr_i)) begin
                rt_hit = 1'b1;
`ifdef REGWR_ARB_FWD_EN
                rt_data = data_q[idx];
`endif
            end
        end
    end

`ifdef REGWR_ARB_FWD_EN
    assign stall_o       = 1'b0;
    assign fwd_rs_o      = rs_hit;
    assign fwd_rs_data_o = rs_data;
    assign fwd_rt_o      = rt_hit;
    assign fwd_rt_data_o = rt_data;
`else
    assign stall_o       = rs_hit | rt_hit;
    assign fwd_rs_o      = 1'b0;
    assign fwd_rs_data_o = 32'd0;
    assign fwd_rt_o      = 1'b0;
    assign fwd_rt_data_o = 32'd0;
`endif

    assign RegWrite_o = we_q;
    assign RDaddr_o   = rd_addr_q;
    assign RDdata_o   = rd_data_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a queue-based model of the arbitration rules.
module tb_regwr_arbiter;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, wb_we_i, mc_valid_i;
    logic [4:0]  wb_addr_i, mc_addr_i, rs_addr_i, rt_addr_i;
    logic [31:0] wb_data_i, mc_data_i;
    logic        mc_ready_o, RegWrite_o, stall_o, fwd_rs_o, fwd_rt_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o, fwd_rs_data_o, fwd_rt_data_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffered secondary writes, oldest first.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;
    ent_t mq[$];

    // Values observed in the last cycle before its edge.
    logic        obs_ready, obs_stall, obs_fwd_rs;
    logic [31:0] obs_fwd_rs_data;

    regwr_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
        .mc_addr_i(mc_addr_i), .mc_data_i(mc_data_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .stall_o(stall_o),
        .fwd_rs_o(fwd_rs_o), .fwd_rs_data_o(fwd_rs_data_o),
        .fwd_rt_o(fwd_rt_o), .fwd_rt_data_o(fwd_rt_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance model,
    // check the registered write port after the edge.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md, input logic [4:0] rs, input logic [4:0] rt);
        logic        e_ready, e_rs_hit, e_rt_hit, prim, acc;
        logic [31:0] e_rs_d, e_rt_d;
        logic        n_we;
        logic [4:0]  n_a;
        logic [31:0] n_d;
        ent_t        e;
        rst_i = rst; wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
        mc_valid_i = mv; mc_addr_i = ma; mc_data_i = md;
        rs_addr_i = rs; rt_addr_i = rt;
        @(negedge clk_i);
        e_ready  = !rst && (mq.size() < DEPTH);
        e_rs_hit = 1'b0; e_rt_hit = 1'b0; e_rs_d = 32'd0; e_rt_d = 32'd0;
        foreach (mq[i]) begin
            if (mq[i].live && rs != 5'd0 && mq[i].a == rs) begin e_rs_hit = 1'b1; e_rs_d = mq[i].d; end
            if (mq[i].live && rt != 5'd0 && mq[i].a == rt) begin e_rt_hit = 1'b1; e_rt_d = mq[i].d; end
        end
        obs_ready = mc_ready_o; obs_stall = stall_o;
        obs_fwd_rs = fwd_rs_o; obs_fwd_rs_data = fwd_rs_data_o;
        check("mc_ready", mc_ready_o, e_ready);
`ifdef REGWR_ARB_FWD_EN
        check("stall", stall_o, 0);
        check("fwd_rs", fwd_rs_o, e_rs_hit);
        check("fwd_rs_data", fwd_rs_data_o, e_rs_d);
        check("fwd_rt", fwd_rt_o, e_rt_hit);
        check("fwd_rt_data", fwd_rt_data_o, e_rt_d);
`else
        check("stall", stall_o, e_rs_hit | e_rt_hit);
        check("fwd_rs", fwd_rs_o, 0);
        check("fwd_rs_data", fwd_rs_data_o, 0);
        check("fwd_rt", fwd_rt_o, 0);
        check("fwd_rt_data", fwd_rt_data_o, 0);
`endif
        n_we = 1'b0; n_a = 5'd0; n_d = 32'd0;
        if (rst) begin
            mq.delete();
        end else begin
            prim = we && (wa != 5'd0);
            acc  = mv && e_ready;
            if (prim) begin n_we = 1'b1; n_a = wa; n_d = wd; end
            if (mq.size() > 0) begin
                if (!mq[0].live) void'(mq.pop_front());
                else if (!prim) begin
                    n_we = 1'b1; n_a = mq[0].a; n_d = mq[0].d;
                    void'(mq.pop_front());
                end
            end
            if (prim) begin
                foreach (mq[i]) begin
                    if (mq[i].a == wa) begin e = mq[i]; e.live = 1'b0; mq[i] = e; end
                end
            end
            if (acc && ma != 5'd0) begin
                e.a = ma; e.d = md; e.live = 1'b1;
                mq.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
        check("RegWrite", RegWrite_o, n_we);
        check("RDaddr", RDaddr_o, n_a);
        check("RDdata", RDdata_o, n_d);
    endtask

    task automatic idle(input logic [4:0] rs);
        cyc(0, 0, 0, 0, 0, 0, 0, rs, 0);
    endtask

    initial begin
        // Reset and reset state.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ready_low", obs_ready, 0);
        check("reset_regwrite", RegWrite_o, 0);
        idle(0);
        check("ready_after_reset", obs_ready, 1);

        // Single secondary write: visible two cycles after accept.
        cyc(0, 0, 0, 0, 1, 5, 32'h11, 0, 0);
        check("lat_not_yet", RegWrite_o, 0);
        idle(0);
        check("lat_we", RegWrite_o, 1);
        check("lat_addr", RDaddr_o, 5);
        check("lat_data", RDdata_o, 32'h11);
        idle(0);

        // Primary busy four cycles, secondary r7 waits.
        cyc(0, 1, 3, 32'h30, 1, 7, 32'hAA, 0, 0);
        for (int i = 1; i < 4; i++) cyc(0, 1, 3, 32'h30 + i, 0, 0, 0, 0, 0);
        check("prio_r3_last", RDaddr_o, 3);
        idle(0);
        check("prio_r7_addr", RDaddr_o, 7);
        check("prio_r7_data", RDdata_o, 32'hAA);
        idle(0);

        // Fill the buffer under primary traffic, then drain.
        cyc(0, 1, 1, 32'h1, 1, 8, 32'h8, 0, 0);
        cyc(0, 1, 1, 32'h2, 1, 9, 32'h9, 0, 0);
        cyc(0, 1, 1, 32'h3, 1, 10, 32'hA, 0, 0);
        check("full_not_ready", obs_ready, 0);
        idle(0);
        check("drain_r8", RDaddr_o, 8);
        idle(0);
        check("drain_r9", RDaddr_o, 9);
        check("ready_back", obs_ready, 1);
        idle(0);
        check("no_r10", RegWrite_o, 0);

        // Buffered r4 overtaken by a primary r4 write.
        cyc(0, 1, 1, 32'h5, 1, 4, 32'h1, 0, 0);
        cyc(0, 1, 4, 32'h2, 0, 0, 0, 0, 0);
        check("kill_r4_data", RDdata_o, 32'h2);
        idle(0);
        check("kill_no_write", RegWrite_o, 0);
        idle(0);

        // Hazard on buffered r6.
        cyc(0, 1, 1, 32'h7, 1, 6, 32'hBEEF, 0, 0);
        cyc(0, 1, 1, 32'h8, 0, 0, 0, 6, 0);
`ifdef REGWR_ARB_FWD_EN
        check("haz_fwd", obs_fwd_rs, 1);
        check("haz_fwd_data", obs_fwd_rs_data, 32'hBEEF);
        check("haz_no_stall", obs_stall, 0);
`else
        check("haz_stall", obs_stall, 1);
        check("haz_no_fwd", obs_fwd_rs, 0);
`endif
        idle(6);
        check("haz_r6_written", RDaddr_o, 6);
        idle(6);
        check("haz_cleared", obs_stall, 0);

        // Register 0 writes dropped; reset discards buffered entries.
        cyc(0, 1, 0, 32'h9, 1, 0, 32'h9, 0, 0);
        check("r0_accepted", obs_ready, 1);
        check("r0_no_write", RegWrite_o, 0);
        idle(0);
        check("r0_no_later", RegWrite_o, 0);
        cyc(0, 1, 1, 32'h1, 1, 11, 32'hB, 0, 0);
        cyc(0, 1, 1, 32'h2, 1, 12, 32'hC, 0, 0);
        cyc(1, 1, 1, 32'h3, 0, 0, 0, 0, 0);
        check("rst_out_zero", RegWrite_o, 0);
        idle(0);
        check("rst_ready", obs_ready, 1);
        check("rst_no_write", RegWrite_o, 0);
        idle(0);
        check("rst_no_write2", RegWrite_o, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, secondary-write buffer entries (power of two, 2..8).
REQ-002 The block SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port wb_we_i  in  1  pipeline write-back write enable (primary requester).
REQ-005 The block SHALL have port wb_addr_i  in  5  primary destination register.
REQ-006 The block SHALL have port wb_data_i  in  32  primary write data.
REQ-007 The block SHALL have port mc_valid_i  in  1  multi-cycle unit write request (secondary requester).
REQ-008 The block SHALL have port mc_ready_o  out  1  secondary request accepted this edge when high with mc_valid_i.
REQ-009 The block SHALL have ports mc_addr_i  in  5 and mc_data_i  in  32  secondary destination and data.
REQ-010 The block SHALL have ports rs_addr_i  in  5 and rt_addr_i  in  5  decode-stage source registers for hazard check.
REQ-011 The block SHALL have ports RegWrite_o  out  1, RDaddr_o  out  5, RDdata_o  out  32  single register-file write port.
REQ-012 The block SHALL have port stall_o  out  1  decode stall request.
REQ-013 The block SHALL have ports fwd_rs_o  out  1, fwd_rs_data_o  out  32, fwd_rt_o  out  1, fwd_rt_data_o  out  32  buffer forwarding.

Function
REQ-014 Write-port outputs SHALL be registered; a granted write is presented for exactly one cycle, one cycle after grant.
REQ-015 Primary SHALL have absolute priority: wb_we_i high with wb_addr_i != 0 is granted that edge.
REQ-016 Accepted secondary requests SHALL enter a DEPTH-entry FIFO; mc_ready_o = (count < DEPTH) and not rst_i.
REQ-017 With FIFO full, mc_ready_o SHALL be 0 even if the head drains that edge.
REQ-018 The FIFO head SHALL be granted only on an edge with no primary grant; minimum secondary latency accept-to-RegWrite_o is 2 cycles.
REQ-019 Writes to register 0 SHALL be discarded from either requester: never granted, never buffered (accepted and dropped).
REQ-020 A primary grant to address A SHALL kill every valid FIFO entry with address A (newer data wins).
REQ-021 A killed head SHALL be popped without producing a write cycle, allowing the next live entry to be granted on the following free edge.
REQ-022 A secondary accept and primary grant to the same address on the same edge SHALL keep the secondary entry live (secondary is younger).
REQ-023 Simultaneous accept and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 Hazard: rs_addr_i/rt_addr_i nonzero matching any live FIFO entry is a hit; the youngest matching entry is the source.
REQ-025 Idle cycles SHALL drive RegWrite_o=0, RDaddr_o=0, RDdata_o=0.

Reset
REQ-026 While rst_i is high at a rising edge, the FIFO SHALL empty, all entries invalidate, and all outputs go to 0.
REQ-027 Reset mid-operation SHALL discard pending secondary writes without any further write cycle; mc_ready_o returns to 1 on the first cycle after rst_i falls.

Configuration
REQ-028 Macro REGWR_ARB_FWD_EN defined: on a hit, fwd_*_o=1 and fwd_*_data_o = youngest matching data; stall_o is constantly 0.
REQ-029 REGWR_ARB_FWD_EN undefined: fwd_*_o and fwd_*_data_o are constantly 0; stall_o = rs hit OR rt hit, combinational.

Verification
REQ-030 Reset, then mc write r5=0x11 with wb idle -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0x11 exactly 2 cycles after accept.
REQ-031 wb writes r3 every cycle for 4 cycles while mc writes r7=0xAA -> r3 writes on cycles 1-4, r7 write on cycle 5, no lost writes.
REQ-032 Fill DEPTH=2 with r8, r9 under continuous wb traffic -> mc_ready_o=0; stop wb -> r8 then r9 on consecutive cycles, ready returns.
REQ-033 Buffer r4=0x1 while wb busy, then wb writes r4=0x2 -> single r4 write of 0x2; no later r4 write.
REQ-034 Buffer r6=0xBEEF, rs_addr_i=6 -> FWD_EN: fwd_rs_o=1, data 0xBEEF, stall_o=0; without FWD_EN: stall_o=1 until r6 written.
REQ-035 mc write r0 and wb write r0 -> accepted, no RegWrite_o pulse; assert rst_i with 2 entries buffered -> no further writes, mc_ready_o=1 afterward.
